adxl355_sample_collector: RTL and testbench

- Host-side sequencer that sits directly on top of the I2C master controller. It drives the controller's 32-bit control word to launch an 11-byte hardware-mode burst read from the ADXL355, starting at TEMP2 (0x06).
- It watches the controller status word and, on completion, captures the 11 read bytes. It unpacks them into a 12-bit temperature and three signed 20-bit acceleration samples, and emits a single-cycle valid strobe to the downstream sensor-fusion logic.
- Adds a timeout watchdog plus frame, overrun and timeout counters.

---
 rtl/adxl355_sample_collector_if.sv | 10 +
 rtl/adxl355_sample_collector.sv | 189 ++++++++++++++++++
 tb/tb_adxl355_sample_collector.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adxl355_sample_collector_if.sv
// Link between the sample collector and the I2C master controller:
// the control word goes out, and the status word and burst read bytes come back.
interface adxl355_sample_collector_if;
  logic [31:0] ctrl;
  logic [31:0] status;
  logic [87:0] rd_bus;

  modport master (output ctrl, input status, input rd_bus);
  modport slave  (input ctrl, output status, output rd_bus);
endinterface

// File: rtl/adxl355_sample_collector.sv
// Launches an 11-byte ADXL355 burst read per trigger and unpacks temp/X/Y/Z; o_valid comes 2 cycles after fin_rise.
// There is no backpressure: a trigger that arrives while busy is dropped and counted as an overrun.
module adxl355_sample_collector #(
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_trig,
  adxl355_sample_collector_if.master  ctrl_if,
  output logic [11:0]                 o_temp,
  output logic [19:0]                 o_x,
  output logic [19:0]                 o_y,
  output logic [19:0]                 o_z,
  output logic                        o_valid,
  output logic                        o_busy,
  output logic                        o_timeout,
  output logic [CNT_W-1:0]            o_frame_cnt,
  output logic [CNT_W-1:0]            o_ovr_cnt,
  output logic [CNT_W-1:0]            o_to_cnt
);

  localparam int unsigned      TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [31:0]      CTRL_RD  = 32'h0000_000A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_LAUNCH,
    S_WAIT_FIN,
    S_CAPTURE,
    S_OUTPUT
  } state_e;

  typedef struct packed {
    logic [11:0] temp;
    logic [19:0] x;
    logic [19:0] y;
    logic [19:0] z;
  } sample_t;

  state_e            state_q, state_d;
  logic              en_q, en_d;
  logic              armed_q, armed_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  sample_t           frame_q, frame_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  ovr_cnt_q, ovr_cnt_d;
  logic [CNT_W-1:0]  to_tot_q, to_tot_d;

  logic rdy_meta_q, rdy_s_q;
  logic fin_meta_q, fin_s_q, fin_prev_q;
  logic fin_rise;
  logic active;
  logic valid;
  logic timeout;
  logic unused_ok;

  // Status bits come from the controller's i2c_clk domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
      fin_meta_q <= 1'b0;
      fin_s_q    <= 1'b0;
      fin_prev_q <= 1'b0;
    end else begin
      rdy_meta_q <= ctrl_if.status[0];
      rdy_s_q    <= rdy_meta_q;
      fin_meta_q <= ctrl_if.status[1];
      fin_s_q    <= fin_meta_q;
      fin_prev_q <= fin_s_q;
    end
  end

  assign fin_rise = fin_s_q & ~fin_prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      armed_q     <= 1'b0;
      to_cnt_q    <= '0;
      frame_q     <= '0;
      frame_cnt_q <= '0;
      ovr_cnt_q   <= '0;
      to_tot_q    <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      armed_q     <= armed_d;
      to_cnt_q    <= to_cnt_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
      to_tot_q    <= to_tot_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    armed_d     = armed_q;
    to_cnt_d    = to_cnt_q;
    frame_d     = frame_q;
    frame_cnt_d = frame_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    to_tot_d    = to_tot_q;
    valid       = 1'b0;
    timeout     = 1'b0;
    active      = (state_q == S_WAIT_RDY) || (state_q == S_LAUNCH) || (state_q == S_WAIT_FIN);

    if (i_trig && (state_q != S_IDLE)) begin
      ovr_cnt_d = ovr_cnt_q + CNT_ONE;
    end
    if (active) begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (i_trig) begin
          to_cnt_d = '0;
          state_d  = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (rdy_s_q) begin
          en_d    = 1'b1;
          armed_d = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      // Drop en as soon as the controller leaves IDLE so it cannot re-arm on return.
      S_LAUNCH: begin
        if (!rdy_s_q) begin
          en_d    = 1'b0;
          state_d = S_WAIT_FIN;
        end
      end
      S_WAIT_FIN: begin
        if (fin_rise) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        frame_d.temp = {ctrl_if.rd_bus[83:80], ctrl_if.rd_bus[79:72]};
        frame_d.x    = ctrl_if.rd_bus[71:52];
        frame_d.y    = ctrl_if.rd_bus[47:28];
        frame_d.z    = ctrl_if.rd_bus[23:4];
        state_d      = S_OUTPUT;
      end
      S_OUTPUT: begin
        valid       = 1'b1;
        frame_cnt_d = frame_cnt_q + CNT_ONE;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (active && (to_cnt_q == TO_LAST)) begin
      en_d     = 1'b0;
      timeout  = 1'b1;
      to_tot_d = to_tot_q + CNT_ONE;
      state_d  = S_IDLE;
    end
  end

  // Control word stays all-zero until the first launch.
  assign ctrl_if.ctrl = armed_q ? (CTRL_RD | {31'b0, en_q}) : 32'h0;

  assign o_temp      = frame_q.temp;
  assign o_x         = frame_q.x;
  assign o_y         = frame_q.y;
  assign o_z         = frame_q.z;
  assign o_valid     = valid;
  assign o_busy      = (state_q != S_IDLE);
  assign o_timeout   = timeout;
  assign o_frame_cnt = frame_cnt_q;
  assign o_ovr_cnt   = ovr_cnt_q;
  assign o_to_cnt    = to_tot_q;

  assign unused_ok = ^{ctrl_if.status[31:2], ctrl_if.rd_bus[87:84],
                       ctrl_if.rd_bus[51:48], ctrl_if.rd_bus[27:24], ctrl_if.rd_bus[3:0]};

endmodule

// File: tb/tb_adxl355_sample_collector.sv
// Directed bench for adxl355_sample_collector: stimulus pushes expected samples and
// strobe cycles into queues, and a negedge monitor pops and compares them.
module tb_adxl355_sample_collector;

  localparam int unsigned TO_CYC = 100;
  localparam int unsigned CW     = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          trig  = 1'b0;
  logic          rdy   = 1'b0;
  logic          fin   = 1'b0;
  logic [87:0]   rd    = '0;
  logic [11:0]   temp;
  logic [19:0]   x, y, z;
  logic          valid, busy, tmo;
  logic [CW-1:0] frame_cnt, ovr_cnt, to_cnt;

  adxl355_sample_collector_if bus ();

  assign bus.status = {30'b0, fin, rdy};
  assign bus.rd_bus = rd;

  adxl355_sample_collector #(.TIMEOUT_CYC(TO_CYC), .CNT_W(CW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_trig      (trig),
    .ctrl_if     (bus),
    .o_temp      (temp),
    .o_x         (x),
    .o_y         (y),
    .o_z         (z),
    .o_valid     (valid),
    .o_busy      (busy),
    .o_timeout   (tmo),
    .o_frame_cnt (frame_cnt),
    .o_ovr_cnt   (ovr_cnt),
    .o_to_cnt    (to_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [11:0] temp;
    logic [19:0] x;
    logic [19:0] y;
    logic [19:0] z;
  } smp_t;

  smp_t exp_q[$];
  int   exp_cyc_q[$];
  int   to_cyc_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  smp_t mon_e;
  int   mon_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("valid_cycle", 64'(cyc), 64'(mon_c));
        check("temp", 64'(temp), 64'(mon_e.temp));
        check("x", 64'(x), 64'(mon_e.x));
        check("y", 64'(y), 64'(mon_e.y));
        check("z", 64'(z), 64'(mon_e.z));
      end
    end
    if (tmo) begin
      if (to_cyc_q.size() == 0) begin
        check("unexpected_timeout", 64'(tmo), 64'd0);
      end else begin
        mon_c = to_cyc_q.pop_front();
        check("timeout_cycle", 64'(cyc), 64'(mon_c));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_access();
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
  endtask

  task automatic handshake();
    int n = 0;
    while (bus.ctrl !== 32'hB && n < 20) begin
      tick(1);
      n++;
    end
    check("launch_en", 64'(bus.ctrl), 64'hB);
    rdy = 1'b0;
  endtask

  // Finish rises now; o_valid is due 4 edges later (2 sync + CAPTURE + OUTPUT).
  task automatic finish(input logic [87:0] bytes, input smp_t e, input bit trig_in_output);
    rd  = bytes;
    fin = 1'b1;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + 4);
    tick(4);
    if (trig_in_output) trig = 1'b1;
    tick(1);
    trig = 1'b0;
    fin  = 1'b0;
    rdy  = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"},  64'(bus.ctrl), 64'd0);
    check({tag, "_temp"},  64'(temp), 64'd0);
    check({tag, "_x"},     64'(x), 64'd0);
    check({tag, "_y"},     64'(y), 64'd0);
    check({tag, "_z"},     64'(z), 64'd0);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_tmo"},   64'(tmo), 64'd0);
    check({tag, "_frm"},   64'(frame_cnt), 64'd0);
    check({tag, "_ovr"},   64'(ovr_cnt), 64'd0);
    check({tag, "_to"},    64'(to_cnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad;
    smp_t e1, e2, e3;
    e1 = '{temp: 12'hABC, x: 20'h12345, y: 20'hFFFFF, z: 20'h80000};
    e2 = '{temp: 12'h501, x: 20'h7FFFF, y: 20'h00001, z: 20'hFF800};
    e3 = '{temp: 12'hCDE, x: 20'hABCDE, y: 20'h55AA5, z: 20'h01234};

    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Nominal frame with a slow-ready launch handshake.
    rdy = 1'b0;
    start_access();
    bad = 0;
    repeat (50) begin
      if (bus.ctrl !== 32'h0) bad++;
      tick(1);
    end
    check("ctrl_before_rdy", 64'(bad), 64'd0);
    rdy = 1'b1;
    tick(2);
    check("ctrl_rdy_in_sync", 64'(bus.ctrl), 64'h0);
    tick(1);
    check("ctrl_en_set", 64'(bus.ctrl), 64'hB);
    rdy = 1'b0;
    tick(2);
    check("ctrl_en_held", 64'(bus.ctrl), 64'hB);
    tick(1);
    check("ctrl_en_clear", 64'(bus.ctrl), 64'hA);
    check("busy_wait_fin", 64'(busy), 64'd1);
    tick(1);
    finish(88'h0A_BC_12_34_50_FF_FF_F0_80_00_00, e1, 1'b0);

    // Back-to-back: trigger in the cycle right after o_valid.
    start_access();
    check("b2b_accepted", 64'(busy), 64'd1);
    handshake();
    tick(4);
    finish(88'hF5_01_7F_FF_F9_00_00_1A_FF_80_0F, e2, 1'b0);
    tick(3);
    check("frame_cnt_2", 64'(frame_cnt), 64'd2);
    check("ovr_cnt_0", 64'(ovr_cnt), 64'd0);

    // Overrun: three triggers in WAIT_FIN, plus one in the OUTPUT cycle.
    start_access();
    handshake();
    tick(4);
    repeat (3) begin
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
      tick(1);
    end
    check("ovr_cnt_3", 64'(ovr_cnt), 64'd3);
    finish(88'h3C_DE_AB_CD_E7_55_AA_5F_01_23_4C, e3, 1'b1);
    tick(3);
    check("ovr_cnt_output", 64'(ovr_cnt), 64'd4);
    check("frame_cnt_3", 64'(frame_cnt), 64'd3);
    check("output_trig_dropped", 64'(busy), 64'd0);

    // Timeout: ready rises and falls but finish never comes.
    to_cyc_q.push_back(cyc + TO_CYC);
    start_access();
    handshake();
    bad = 0;
    while (busy && bad < 150) begin
      tick(1);
      bad++;
    end
    tick(2);
    check("timeout_seen", 64'(to_cyc_q.size()), 64'd0);
    check("to_cnt_1", 64'(to_cnt), 64'd1);
    check("to_frame_cnt", 64'(frame_cnt), 64'd3);
    check("to_ctrl", 64'(bus.ctrl), 64'hA);
    check("to_temp_held", 64'(temp), 64'(e3.temp));
    check("to_x_held", 64'(x), 64'(e3.x));
    check("to_z_held", 64'(z), 64'(e3.z));

    // Async reset in WAIT_FIN, then an orphan finish pulse.
    rdy = 1'b1;
    start_access();
    handshake();
    tick(4);
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1 check_zero("midreset");
    tick(2);
    rst_n = 1'b1;
    rdy   = 1'b1;
    tick(2);
    rd  = 88'h0A_BC_12_34_50_FF_FF_F0_80_00_00;
    fin = 1'b1;
    tick(10);
    fin = 1'b0;
    tick(2);
    check("orphan_frame_cnt", 64'(frame_cnt), 64'd0);
    check("orphan_busy", 64'(busy), 64'd0);
    check("orphan_temp", 64'(temp), 64'd0);

    check("missing_valid", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
